// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared widths, FSM state and access-size encodings for the LSU
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int RAM_ADDRESS_WIDTH = 18;
  localparam int BYTE_EN_WIDTH     = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // funct3 encodings of the RV32 load/store size field
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } mem_size_e;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_core_if / lsu_mem_if
// Purpose  : Execute/writeback-side and memory-side buses of the LSU
// Revision : 1.0 - initial release
// ============================================================================

// Pipeline side: master = execute stage, slave = load/store unit
interface lsu_core_if;
  import load_store_unit_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// Memory side: master = load/store unit, slave = data memory
interface lsu_mem_if;
  import load_store_unit_pkg::*;

  logic                         mem_req;
  logic                         mem_we;
  logic [BYTE_EN_WIDTH-1:0]     mem_be;
  logic [RAM_ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]        mem_wdata;
  logic [DATA_WIDTH-1:0]        mem_rdata;
  logic                         mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane logic: legality check, byte enables, store
//            lane replication and load lane extraction with extension
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic                     store,
  input  logic [2:0]               funct3,
  input  logic [1:0]               offset,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     illegal,
  output logic [BYTE_EN_WIDTH-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]    store_data,
  output logic [DATA_WIDTH-1:0]    load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Misaligned halves/words, reserved encodings and unsigned stores are rejected
  always_comb begin
    case (funct3)
      LS_B:    illegal = 1'b0;
      LS_H:    illegal = offset[0];
      LS_W:    illegal = (offset != 2'b00);
      LS_BU:   illegal = store;
      LS_HU:   illegal = store | offset[0];
      default: illegal = 1'b1;
    endcase
  end

  // Store lanes: replicate the datum across the word, enables pick the lane
  always_comb begin
    byte_en    = 4'b1111;
    store_data = wdata;
    if (store) begin
      case (funct3)
        LS_B: begin
          byte_en    = 4'b0001 << offset;
          store_data = {4{wdata[7:0]}};
        end
        LS_H: begin
          byte_en    = offset[1] ? 4'b1100 : 4'b0011;
          store_data = {2{wdata[15:0]}};
        end
        default: begin
          byte_en    = 4'b1111;
          store_data = wdata;
        end
      endcase
    end
  end

  // Load lanes: select by offset, then sign- or zero-extend by funct3
  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LS_B:    load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      LS_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      LS_H:    load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      LS_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      LS_W:    load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle load/store unit: request latch, IDLE/ACCESS/RESP
//            FSM, memory-ack timeout and response register
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e                   state;
  lsu_state_e                   state_next;
  logic [CNT_W-1:0]             cnt;
  logic                         store_q;
  logic [2:0]                   funct3_q;
  logic [RAM_ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [DATA_WIDTH-1:0]        rdata_q;
  logic                         err_q;

  logic                         accept;
  logic                         al_store;
  logic [2:0]                   al_funct3;
  logic [1:0]                   al_offset;
  logic [DATA_WIDTH-1:0]        al_wdata;
  logic                         al_illegal;
  logic [BYTE_EN_WIDTH-1:0]     al_be;
  logic [DATA_WIDTH-1:0]        al_store_data;
  logic [DATA_WIDTH-1:0]        al_load_data;
  logic                         unused_addr_hi;

  // Address bits above the RAM window are intentionally discarded
  assign unused_addr_hi = ^core.req_addr[DATA_WIDTH-1:RAM_ADDRESS_WIDTH];

  assign accept = core.req_valid && (state == IDLE);

  // In IDLE the aligner judges the incoming request; afterwards the latched one
  always_comb begin
    al_store  = store_q;
    al_funct3 = funct3_q;
    al_offset = addr_q[1:0];
    al_wdata  = wdata_q;
    if (state == IDLE) begin
      al_store  = core.req_store;
      al_funct3 = core.req_funct3;
      al_offset = core.req_addr[1:0];
      al_wdata  = core.req_wdata;
    end
  end

  lsu_align u_align (
    .store      (al_store),
    .funct3     (al_funct3),
    .offset     (al_offset),
    .wdata      (al_wdata),
    .rdata      (mem.mem_rdata),
    .illegal    (al_illegal),
    .byte_en    (al_be),
    .store_data (al_store_data),
    .load_data  (al_load_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state: illegal accesses skip the memory cycle entirely
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = al_illegal ? RESP : ACCESS;
      ACCESS:  if (mem.mem_ack || (cnt == CNT_LAST)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      store_q  <= core.req_store;
      funct3_q <= core.req_funct3;
      addr_q   <= core.req_addr[RAM_ADDRESS_WIDTH-1:0];
      wdata_q  <= core.req_wdata;
      rdata_q  <= '0;
      err_q    <= al_illegal;
      cnt      <= '0;
    end else if (state == ACCESS) begin
      if (mem.mem_ack) begin
        rdata_q <= store_q ? '0 : al_load_data;
        err_q   <= 1'b0;
        cnt     <= '0;
      end else if (cnt == CNT_LAST) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // FSM outputs: memory port is driven only in ACCESS, response only in RESP
  always_comb begin
    core.req_ready  = (state == IDLE);
    core.resp_valid = (state == RESP);
    core.resp_rdata = (state == RESP) ? rdata_q : '0;
    core.resp_err   = (state == RESP) ? err_q : 1'b0;
    mem.mem_req     = (state == ACCESS);
    mem.mem_we      = (state == ACCESS) && store_q;
    mem.mem_be      = (state == ACCESS) ? al_be : '0;
    mem.mem_addr    = (state == ACCESS) ? {addr_q[RAM_ADDRESS_WIDTH-1:2], 2'b00} : '0;
    mem.mem_wdata   = ((state == ACCESS) && store_q) ? al_store_data : '0;
  end

endmodule
`default_nettype wire
